fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/core_pkg.sv | 13 +
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared instruction constants and fetch FSM state encoding
package core_pkg;

   localparam logic [31:0] NOP_INST   = 32'h0000_0033;
   localparam logic [31:0] HALT_INST  = 32'h0000_007F;
   localparam logic [31:0] INST_BYTES = 32'd4;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing, IF/ID payload register and RUN/HALTED fetch FSM
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_valid,
   output logic        halted
);

   fetch_state_t r_state;
   fetch_state_t w_next_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_if_pc;
   logic [31:0]  r_if_inst;
   logic         r_if_valid;
   logic [31:0]  w_next_pc;
   logic         w_fetch;
   logic         w_is_halt;
   logic         w_halted;

   assign imem_addr = r_pc;
   assign if_pc     = r_if_pc;
   assign if_inst   = r_if_inst;
   assign if_valid  = r_if_valid;
   assign halted    = w_halted;

   // A fetch is accepted only in RUN when neither stalled nor redirected.
   always_comb begin
      w_fetch   = (r_state == ST_RUN) && !stall && !redirect;
      w_is_halt = w_fetch && (imem_inst == HALT_INST);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (redirect) begin
         w_next_state = ST_RUN;
      end else if (w_is_halt) begin
         w_next_state = ST_HALTED;
      end
   end

   always_comb begin
      w_halted = (r_state == ST_HALTED);
   end

   // The PC parks on a HALT word so a later redirect is the only way out.
   always_comb begin
      w_next_pc = r_pc;
      if (redirect) begin
         w_next_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (w_fetch && !w_is_halt) begin
         w_next_pc = r_pc + INST_BYTES;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC;
         r_if_pc    <= 32'h0000_0000;
         r_if_inst  <= NOP_INST;
         r_if_valid <= 1'b0;
      end else begin
         r_pc <= w_next_pc;
         if (redirect || (r_state == ST_HALTED)) begin
            r_if_inst  <= NOP_INST;
            r_if_valid <= 1'b0;
         end else if (w_fetch) begin
            r_if_pc    <= r_pc;
            r_if_inst  <= imem_inst;
            r_if_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit
module tb_fetch_unit;

   localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFFC;
   localparam logic [31:0] NOP_W       = 32'h0000_0033;
   localparam logic [31:0] HALT_W      = 32'h0000_007F;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_valid;
   logic        halted;

   logic        halt_en;
   logic [31:0] halt_addr;

   typedef struct {
      int          tag;
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp;
   int          n_fail;
   int          cyc;

   logic [31:0] m_pc;
   logic        m_halted;
   logic        m_valid;

   fetch_unit #(
      .RESET_PC (TB_RESET_PC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_inst   (imem_inst),
      .if_pc       (if_pc),
      .if_inst     (if_inst),
      .if_valid    (if_valid),
      .halted      (halted)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a, input logic hen,
                                            input logic [31:0] ha);
      if (hen && a == ha) return HALT_W;
      return {a[26:2] ^ 25'h1AB_CDE5 ^ {20'd0, a[31:27]}, 7'h13};
   endfunction

   assign imem_inst = mem_word(imem_addr, halt_en, halt_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_state();
      chk("imem_addr", imem_addr, m_pc);
      chk("halted", {31'd0, halted}, {31'd0, m_halted});
      chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
      if (!m_valid) chk("bubble_nop", if_inst, NOP_W);
   endtask

   // Reference: what the next edge does to the architectural fetch state.
   task automatic model_update();
      logic [31:0] w;
      exp_t        e;
      if (!rst_n) begin
         m_pc = TB_RESET_PC; m_halted = 1'b0; m_valid = 1'b0;
      end else if (redirect) begin
         m_pc = redirect_pc & ~32'd3; m_halted = 1'b0; m_valid = 1'b0;
      end else if (m_halted) begin
         m_valid = 1'b0;
      end else if (!stall) begin
         w = mem_word(m_pc, halt_en, halt_addr);
         e.tag = cyc + 1; e.pc = m_pc; e.inst = w;
         sb_q.push_back(e);
         m_valid = 1'b1;
         if (w == HALT_W) m_halted = 1'b1;
         else m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rp);
      @(negedge clk);
      check_state();
      rst_n = r; stall = s; redirect = rd; redirect_pc = rp;
      model_update();
   endtask

   // Monitor: each edge that accepts a fetch must present the queued instruction.
   initial begin
      logic take;
      exp_t e;
      forever begin
         @(posedge clk);
         take = rst_n && !stall && !redirect;
         #1;
         cyc++;
         if (sb_q.size() > 0 && sb_q[0].tag == cyc) begin
            e = sb_q.pop_front();
            chk("sb_valid", {31'd0, if_valid}, 32'd1);
            chk("sb_pc", if_pc, e.pc);
            chk("sb_inst", if_inst, e.inst);
         end else if (take && if_valid) begin
            chk("sb_unexpected_fetch", if_pc, 32'hDEAD_BEEF);
         end
      end
   end

   initial begin
      n_cmp = 0; n_fail = 0; cyc = 0;
      rst_n = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0100;
      halt_en = 1'b0; halt_addr = 32'h0;
      m_pc = TB_RESET_PC; m_halted = 1'b0; m_valid = 1'b0;

      step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("reset_if_pc", if_pc, 32'h0);
      chk("reset_if_inst", if_inst, NOP_W);

      // Straight line across the wrap from the top of the address space.
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
      // Stall with data held, then resume.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      // Redirect with misaligned target wins over stall.
      step(1'b1, 1'b1, 1'b1, 32'h0000_0041);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);

      // Halt at 0x54, stay halted regardless of stall, then flush to 0x38.
      halt_en = 1'b1; halt_addr = 32'h0000_0054;
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) step(1'b1, i[0], 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h0000_0038);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
      // Reset while halted, then reset mid-stall.
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);

      halt_en = 1'b1; halt_addr = 32'h0000_0080;
      for (int i = 0; i < 2000; i++) begin
         logic        r, s, rd;
         logic [31:0] rp;
         r  = ($urandom_range(0, 99) != 0);
         s  = ($urandom_range(0, 3) == 0);
         rd = ($urandom_range(0, 11) == 0);
         rp = $urandom_range(0, 63) * 4 + $urandom_range(0, 3);
         step(r, s, rd, rp);
      end
      step(1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      check_state();
      repeat (2) @(negedge clk);
      chk("sb_drain", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
